// File: rtl/poly_pkg.sv
// poly_pkg -- shared constants and narrowing helpers for poly_pipeline.
//   Default widths for the evaluator, plus the signed narrowing function
//   used by every Horner stage and by the output register.
//   Optional feature macro: POLY_SAT_EN
//     defined   -> narrow() saturates to the signed range of the target width
//     undefined -> narrow() is two's-complement truncation (wrap), no compares
//   Helpers operate on a fixed 128-bit signed container; callers size-cast
//   the result down to the width they asked for.
package poly_pkg;

  localparam int POLY_W_DEF     = 16;
  localparam int POLY_ORDER_DEF = 2;
  localparam int POLY_ACC_W_DEF = 32;

  // Widest value any caller may hand to narrow(); ACC_W+W must fit.
  localparam int NARROW_MAXW = 128;

  typedef logic signed [NARROW_MAXW-1:0] wide_t;

  // Keep the low w bits and sign-extend them back over the container.
  function automatic wide_t trunc_narrow(input wide_t v, input int w);
    wide_t r;
    r = v <<< (NARROW_MAXW - w);
    r = r >>> (NARROW_MAXW - w);
    return r;
  endfunction

`ifdef POLY_SAT_EN
  // Clamp to [-2^(w-1), 2^(w-1)-1]; the minimum is the bitwise complement
  // of the maximum in two's complement.
  function automatic wide_t sat_narrow(input wide_t v, input int w);
    wide_t one;
    wide_t hi;
    wide_t lo;
    one = wide_t'(1);
    hi  = (one <<< (w - 1)) - one;
    lo  = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic wide_t narrow(input wide_t v, input int w);
    return sat_narrow(v, w);
  endfunction
`else
  function automatic wide_t narrow(input wide_t v, input int w);
    return trunc_narrow(v, w);
  endfunction
`endif

endpackage

// File: rtl/poly_pipeline_stage.sv
// poly_stage -- one Horner multiply-add stage of poly_pipeline.
//   acc_out <= narrow_ACC_W(acc_in * x_in + coef), x_out <= x_in,
//   v_out <= v_in, all gated by the global advance `adv`.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     adv             pipeline advance (0 = hold everything)
//     v_in/x_in/acc_in   previous stage valid, sample, accumulator
//     coef            coefficient for this order, c[ORDER-k]
//     v_out/x_out/acc_out registered stage outputs
//   Narrowing follows POLY_SAT_EN through poly_pkg::narrow().
module poly_stage
  import poly_pkg::*;
#(
  parameter int W     = POLY_W_DEF,
  parameter int ACC_W = POLY_ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    adv,
  input  logic                    v_in,
  input  logic signed [W-1:0]     x_in,
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic signed [W-1:0]     coef,
  output logic                    v_out,
  output logic signed [W-1:0]     x_out,
  output logic signed [ACC_W-1:0] acc_out
);

  localparam int PW = ACC_W + W;

  // Full-precision product; |acc*x| <= 2^(PW-2) so adding a W-bit
  // coefficient cannot overflow PW bits.
  logic signed [PW-1:0]    mac;
  logic signed [ACC_W-1:0] acc_nxt;

  always_comb begin
    mac     = PW'(acc_in) * PW'(x_in) + PW'(coef);
    acc_nxt = ACC_W'(narrow(wide_t'(mac), ACC_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_out   <= 1'b0;
      x_out   <= '0;
      acc_out <= '0;
    end else if (adv) begin
      // Data registers advance even for bubbles; only v_out qualifies them.
      v_out   <= v_in;
      x_out   <= x_in;
      acc_out <= acc_nxt;
    end
  end

endmodule

// File: rtl/poly_pipeline.sv
// poly_pipeline -- fully pipelined Horner polynomial evaluator
//   Y = c[ORDER]*X^ORDER + ... + c[1]*X + c[0]
//   Stage 0 registers X and seeds the accumulator with c[ORDER]; each of
//   ORDER poly_stage instances folds in one more coefficient. Latency is
//   ORDER+1 cycles; one global advance stalls every stage together.
//   Parameters: W (sample/coef/result width), ORDER (>=1), ACC_W (>=2*W)
//   Ports:
//     clk, rst               clock, synchronous active-high reset
//     in_valid/in_ready/X    sample input handshake
//     out_valid/out_ready/Y  result output handshake
//     coef_we/coef_addr/coef_data  coefficient bank write port (c[k])
//     busy                   any stage holds a valid sample
//   Optional feature macro: POLY_SAT_EN (saturating instead of wrapping
//   narrowing in every stage and on Y).
module poly_pipeline
  import poly_pkg::*;
#(
  parameter int W     = POLY_W_DEF,
  parameter int ORDER = POLY_ORDER_DEF,
  parameter int ACC_W = POLY_ACC_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [W-1:0]        X,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [W-1:0]        Y,
  input  logic                       coef_we,
  input  logic [$clog2(ORDER+1)-1:0] coef_addr,
  input  logic signed [W-1:0]        coef_data,
  output logic                       busy
);

  localparam int AW = $clog2(ORDER + 1);

  if (ORDER < 1)          begin : g_bad_order $error("ORDER must be >= 1"); end
  if (ACC_W < 2 * W)      begin : g_bad_accw  $error("ACC_W must be >= 2*W"); end
  if (ACC_W + W > NARROW_MAXW) begin : g_bad_wide $error("ACC_W+W exceeds narrowing container"); end

  // Coefficient bank, c[k] at index k.
  logic signed [W-1:0] coef_q [ORDER+1];

  // Stage chains; index 0 is the input register, ORDER is the output.
  logic [ORDER:0]            vld_pipe;
  logic [ORDER:0][W-1:0]     x_pipe;
  logic [ORDER:0][ACC_W-1:0] acc_pipe;

  logic adv;
  logic accept;

  assign out_valid = vld_pipe[ORDER];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign accept    = in_valid && adv;
  assign busy      = |vld_pipe;

  // Addresses above ORDER match no entry and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= ORDER; k++) coef_q[k] <= '0;
    end else if (coef_we) begin
      for (int k = 0; k <= ORDER; k++)
        if (coef_addr == AW'(k)) coef_q[k] <= coef_data;
    end
  end

  // Stage 0: capture X and seed the accumulator with the leading coefficient.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[0] <= 1'b0;
      x_pipe[0]   <= '0;
      acc_pipe[0] <= '0;
    end else if (accept) begin
      vld_pipe[0] <= 1'b1;
      x_pipe[0]   <= X;
      acc_pipe[0] <= ACC_W'(coef_q[ORDER]);
    end else if (adv) begin
      vld_pipe[0] <= 1'b0;
    end
  end

  for (genvar g = 1; g <= ORDER; g++) begin : g_stage
    poly_stage #(
      .W     (W),
      .ACC_W (ACC_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .adv     (adv),
      .v_in    (vld_pipe[g-1]),
      .x_in    (x_pipe[g-1]),
      .acc_in  (acc_pipe[g-1]),
      .coef    (coef_q[ORDER-g]),
      .v_out   (vld_pipe[g]),
      .x_out   (x_pipe[g]),
      .acc_out (acc_pipe[g])
    );
  end

  // Output narrowing is combinational off the last stage register, so Y
  // reads 0 straight out of reset.
  always_comb begin
    Y = W'(narrow(wide_t'($signed(acc_pipe[ORDER])), W));
  end

endmodule

// File: tb/tb_poly_pipeline.sv
module tb_poly_pipeline;
  localparam int W = 16, ORDER = 2, ACC_W = 32;
  localparam int BW = 8, BORDER = 3, BACC_W = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, coef_we, busy;
  logic signed [W-1:0] X, Y, coef_data;
  logic [1:0] coef_addr;

  logic b_in_valid, b_in_ready, b_out_valid, b_coef_we, b_busy;
  logic signed [BW-1:0] b_X, b_Y, b_coef_data;
  logic [1:0] b_coef_addr;

  poly_pipeline #(.W(W), .ORDER(ORDER), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .X(X),
    .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy));

  poly_pipeline #(.W(BW), .ORDER(BORDER), .ACC_W(BACC_W)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .X(b_X),
    .out_valid(b_out_valid), .out_ready(1'b1), .Y(b_Y), .coef_we(b_coef_we),
    .coef_addr(b_coef_addr), .coef_data(b_coef_data), .busy(b_busy));

  int checks = 0, failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: straight Horner evaluation in 64-bit arithmetic with
  // the narrowing rule applied after each multiply-add and on the result.
  longint cm [ORDER+1];

  function automatic longint nar(input longint v, input int w);
    longint m;
    longint r;
    m = longint'(1) << w;
`ifdef POLY_SAT_EN
    if (v > m / 2 - 1) return m / 2 - 1;
    if (v < -(m / 2)) return -(m / 2);
    return v;
`else
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
`endif
  endfunction

  function automatic longint model(input longint x);
    longint acc;
    acc = cm[ORDER];
    for (int k = ORDER - 1; k >= 0; k--) acc = nar(acc * x + cm[k], ACC_W);
    return nar(acc, W);
  endfunction

  typedef struct { longint y; int cyc; int stalls; longint x; } exp_t;
  exp_t sb[$];
  int cyc = 0, stalls = 0;

  // Monitor: pops and compares whenever a result is handed over, then
  // records any sample accepted in the same cycle.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        if (!out_ready) begin
          stalls++;
          chk("stall_in_ready", longint'(in_ready), 0);
        end else if (sb.size() == 0) begin
          chk("unexpected_output", longint'(Y), 99999);
        end else begin
          e = sb.pop_front();
          chk($sformatf("Y(x=%0d)", e.x), longint'(Y), e.y);
          chk("latency", cyc - e.cyc, ORDER + 1 + stalls - e.stalls);
        end
      end
      if (in_valid && in_ready)
        sb.push_back('{model(longint'(X)), cyc, stalls, longint'(X)});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_coef(input int addr, input longint data);
    coef_we = 1'b1; coef_addr = 2'(addr); coef_data = W'(data);
    tick();
    coef_we = 1'b0;
    if (addr <= ORDER) cm[addr] = data;
  endtask

  task automatic send(input longint x);
    int n;
    logic ok;
    n = 0;
    in_valid = 1'b1; X = W'(x);
    forever begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      if (ok) break;
      if (++n > 200) begin chk("send_timeout", n, 0); break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin tick(); n++; end
    if (n >= 500) chk("drain_timeout", n, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k <= ORDER; k++) cm[k] = 0;
  endtask

  initial begin
    int n;
    logic signed [15:0] r16;
    rst = 1'b1; in_valid = 1'b0; X = '0; out_ready = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    b_in_valid = 1'b0; b_X = '0; b_coef_we = 1'b0; b_coef_addr = '0; b_coef_data = '0;
    for (int k = 0; k <= ORDER; k++) cm[k] = 0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_Y", longint'(Y), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    out_ready = 1'b1;

    // Directed stream with one bubble after -1.
    wr_coef(2, 1); wr_coef(1, 2); wr_coef(0, 3);
    for (int x = -3; x <= 3; x++) begin
      send(x);
      if (x == -1) tick();
    end
    drain();

    // Saturation / wrap boundary.
    wr_coef(2, 0); wr_coef(1, 100); wr_coef(0, 0);
    send(400); send(-400);
    drain();

    // Continuous stream with a 4-cycle consumer stall mid-way.
    wr_coef(2, 1); wr_coef(1, -7); wr_coef(0, 11);
    fork
      for (int x = 0; x < 10; x++) send(x);
      begin repeat (5) tick(); out_ready = 1'b0; repeat (4) tick(); out_ready = 1'b1; end
    join
    drain();
    chk("stall_seen", longint'(stalls > 0), 1);

    // Reset with two samples in flight.
    send(10); send(11);
    do_reset();
    chk("post_rst_out_valid", longint'(out_valid), 0);
    chk("post_rst_busy", longint'(busy), 0);
    chk("post_rst_in_ready", longint'(in_ready), 1);
    send(5);
    drain();

    // Coefficient writes, including an out-of-range address.
    wr_coef(2, 1); wr_coef(1, 2);
    wr_coef(0, 7); wr_coef(3, 1234);
    send(0); send(1);
    drain();

    // Random coefficients, data, bubbles and backpressure.
    for (int k = 0; k <= ORDER; k++) begin r16 = 16'($urandom); wr_coef(k, longint'(r16)); end
    fork
      for (int i = 0; i < 40; i++) begin
        r16 = 16'($urandom);
        send(longint'(r16));
        if ($urandom_range(0, 3) == 0) tick();
      end
      for (int i = 0; i < 90; i++) begin out_ready = 1'(($urandom_range(0, 2) != 0)); tick(); end
    join
    out_ready = 1'b1;
    drain();

    // ORDER=3, W=8 instance: c3=1, X=-5 -> -125 after 4 cycles.
    b_coef_we = 1'b1; b_coef_addr = 2'd3; b_coef_data = 8'sd1;
    tick();
    b_coef_we = 1'b0;
    b_in_valid = 1'b1; b_X = -8'sd5;
    @(negedge clk); chk("b_in_ready", longint'(b_in_ready), 1);
    tick();
    b_in_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk); n++;
      if (b_out_valid) break;
    end
    chk("b_latency", n, BORDER + 1);
    chk("b_Y", longint'(b_Y), -125);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
